// File: rtl/toggle_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// toggle_burst_ctrl_if
// Bundle of request/status signals between the configuration/control logic
// (master) and the toggle burst sequencer (slave).
//
// Signals:
//   start        master->slave  request a burst
//   half_period  master->slave  cycles between toggles (CNT_W bits)
//   num_toggles  master->slave  toggles per burst (N_W bits)
//   abort        master->slave  terminate an active burst
//   busy         slave->master  burst in progress
//   done         slave->master  one-cycle pulse on normal completion
//   tog_en       slave->master  one-cycle toggle-enable to the T flip-flop
//   tog_q        slave->master  shadow of the T flip-flop state
//   toggles_left slave->master  toggles remaining (N_W bits)
// ---------------------------------------------------------------------------
interface toggle_burst_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int N_W   = 8
);
  logic             start;
  logic [CNT_W-1:0] half_period;
  logic [N_W-1:0]   num_toggles;
  logic             abort;
  logic             busy;
  logic             done;
  logic             tog_en;
  logic             tog_q;
  logic [N_W-1:0]   toggles_left;

  // Requester side: drives the controls, observes the status
  modport master (
    output start, half_period, num_toggles, abort,
    input  busy, done, tog_en, tog_q, toggles_left
  );

  // Sequencer side: observes the controls, drives the status
  modport slave (
    input  start, half_period, num_toggles, abort,
    output busy, done, tog_en, tog_q, toggles_left
  );
endinterface

// File: rtl/toggle_burst_ctrl.sv
// ---------------------------------------------------------------------------
// toggle_burst_ctrl
// Sequencer for the T flip-flop toggle datapath. A start request launches a
// burst of num_toggles single-cycle tog_en pulses spaced half_period cycles
// apart. A shadow copy of the flip-flop state (tog_q) is kept so that an
// abort can return the flip-flop to 0 with one extra restore pulse.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active low
//   bus  toggle_burst_ctrl_if.slave (start/half_period/num_toggles/abort in,
//        busy/done/tog_en/tog_q/toggles_left out)
//
// Build option:
//   TOGGLE_BURST_AUTO_RELOAD_EN - when defined, a completed burst pulses done
//   and immediately restarts with the latched settings until aborted.
// ---------------------------------------------------------------------------
module toggle_burst_ctrl #(
  parameter int CNT_W = 16,
  parameter int N_W   = 8
) (
  input logic                clk,
  input logic                rst,
  toggle_burst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RESTORE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] reloadVal_q, reloadVal_d;
  logic [N_W-1:0]   togglesLeft_q, togglesLeft_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             togEn_q, togEn_d;
  logic             togQ_q, togQ_d;
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
  logic [N_W-1:0]   numLat_q, numLat_d;
`endif

  logic [CNT_W-1:0] startReload;
  logic             counterZero;

  // A half period of 0 behaves like 1, so the reload value saturates at 0
  assign startReload = (bus.half_period == '0) ? '0 : bus.half_period - CNT_W'(1);
  assign counterZero = (counter_q == '0);

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that the registered copies line up with that state.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    reloadVal_d   = reloadVal_q;
    togglesLeft_d = togglesLeft_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    togEn_d       = 1'b0;
    togQ_d        = togQ_q;
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
    numLat_d      = numLat_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // start wins over a simultaneous abort here
        if (bus.start) begin
          reloadVal_d   = startReload;
          counter_d     = startReload;
          togglesLeft_d = bus.num_toggles;
          busy_d        = 1'b1;
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
          numLat_d      = bus.num_toggles;
`endif
          if (bus.num_toggles == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end

      COUNT: begin
        if (bus.abort) begin
          // Abort suppresses this cycle's tick, terminal tick included
          togglesLeft_d = '0;
          counter_d     = '0;
          if (togQ_q) begin
            state_d = RESTORE;
            togEn_d = 1'b1;
            togQ_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else if (togglesLeft_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
          // Preload so the DONE cycle doubles as the first count cycle
          counter_d     = reloadVal_q;
          togglesLeft_d = numLat_q;
`endif
        end else if (counterZero) begin
          togEn_d       = 1'b1;
          togQ_d        = ~togQ_q;
          togglesLeft_d = togglesLeft_q - N_W'(1);
          counter_d     = reloadVal_q;
        end else begin
          counter_d = counter_q - CNT_W'(1);
        end
      end

      RESTORE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      DONE: begin
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
        if (numLat_q != '0) begin
          state_d = COUNT;
          if (counterZero) begin
            togEn_d       = 1'b1;
            togQ_d        = ~togQ_q;
            togglesLeft_d = togglesLeft_q - N_W'(1);
            counter_d     = reloadVal_q;
          end else begin
            counter_d = counter_q - CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = IDLE;
        busy_d  = 1'b0;
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately,
  // without any restore pulse, even mid-burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      reloadVal_q   <= '0;
      togglesLeft_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      togEn_q       <= 1'b0;
      togQ_q        <= 1'b0;
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
      numLat_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      reloadVal_q   <= reloadVal_d;
      togglesLeft_q <= togglesLeft_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      togEn_q       <= togEn_d;
      togQ_q        <= togQ_d;
`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
      numLat_q      <= numLat_d;
`endif
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.tog_en       = togEn_q;
  assign bus.tog_q        = togQ_q;
  assign bus.toggles_left = togglesLeft_q;

endmodule

// File: tb/tb_toggle_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_toggle_burst_ctrl
// Directed bench for toggle_burst_ctrl. Inputs change and outputs are
// sampled 1 time unit after each rising edge, so every sample shows the
// registered result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_toggle_burst_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  toggle_burst_ctrl_if #(.CNT_W(16), .N_W(8)) bus ();

  toggle_burst_ctrl #(.CNT_W(16), .N_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the requester-side controls
  task automatic applyStimulus(input logic s, input logic [15:0] hp,
                               input logic [7:0] n, input logic ab);
    bus.start       = s;
    bus.half_period = hp;
    bus.num_toggles = n;
    bus.abort       = ab;
  endtask

  // Advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every status output against the expected values
  task automatic checkOutput(input string tag, input logic eBusy, input logic eDone,
                             input logic eTogEn, input logic eTogQ, input logic [7:0] eLeft);
    checks++;
    assert (bus.busy === eBusy) else begin
      errors++;
      $error("[TB] FAIL %s.busy observed=%0b expected=%0b", tag, bus.busy, eBusy);
    end
    checks++;
    assert (bus.done === eDone) else begin
      errors++;
      $error("[TB] FAIL %s.done observed=%0b expected=%0b", tag, bus.done, eDone);
    end
    checks++;
    assert (bus.tog_en === eTogEn) else begin
      errors++;
      $error("[TB] FAIL %s.tog_en observed=%0b expected=%0b", tag, bus.tog_en, eTogEn);
    end
    checks++;
    assert (bus.tog_q === eTogQ) else begin
      errors++;
      $error("[TB] FAIL %s.tog_q observed=%0b expected=%0b", tag, bus.tog_q, eTogQ);
    end
    checks++;
    assert (bus.toggles_left === eLeft) else begin
      errors++;
      $error("[TB] FAIL %s.toggles_left observed=%0d expected=%0d", tag, bus.toggles_left, eLeft);
    end
  endtask

  // Expected outputs k cycles into a burst (1 <= k <= n*hp, tog_q starting at 0)
  task automatic checkCountPhase(input string tag, input int hp, input int n, input int k);
    int cnt;
    logic [7:0] left;
    cnt  = k / hp;
    left = 8'(n - cnt);
    checkOutput($sformatf("%s.k%0d", tag, k), 1'b1, 1'b0, (k % hp) == 0, cnt[0], left);
  endtask

  // Directed sequence
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    applyStimulus(1'b0, 16'd0, 8'd0, 1'b0);

    // Reset state
    step();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    step();
    checkOutput("postReset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset mid-burst: hp=1, N=3, reset after first toggle (toggles_left=2)
    applyStimulus(1'b1, 16'd1, 8'd3, 1'b0);
    step();
    checkOutput("rstBurst.start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    applyStimulus(1'b0, 16'd1, 8'd3, 1'b0);
    step();
    checkOutput("rstBurst.k1", 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    rst = 1'b0;
    #2;
    checkOutput("rstAsync", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("rstHeld", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;

`ifdef TOGGLE_BURST_AUTO_RELOAD_EN
    // Auto-reload: hp=1, N=2 -> done every 3 cycles, busy stays high
    applyStimulus(1'b1, 16'd1, 8'd2, 1'b0);
    step();
    checkOutput("reload.start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    applyStimulus(1'b0, 16'd1, 8'd2, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      case (k % 3)
        0:       checkOutput($sformatf("reload.k%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        1:       checkOutput($sformatf("reload.k%0d", k), 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        default: checkOutput($sformatf("reload.k%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      endcase
    end
    applyStimulus(1'b0, 16'd1, 8'd2, 1'b1);
    step();
    checkOutput("reload.restore", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 16'd1, 8'd2, 1'b0);
    step();
    checkOutput("reload.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
`else
    // Basic burst hp=3, N=4, with an ignored start while busy
    applyStimulus(1'b1, 16'd3, 8'd4, 1'b0);
    step();
    checkOutput("basic.start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) applyStimulus(1'b1, 16'd1, 8'd9, 1'b0);
      else        applyStimulus(1'b0, 16'd3, 8'd4, 1'b0);
      step();
      checkCountPhase("basic", 3, 4, k);
    end
    step();
    checkOutput("basic.done", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("basic.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // N=0: done right after acceptance, no toggles
    applyStimulus(1'b1, 16'd7, 8'd0, 1'b0);
    step();
    checkOutput("zeroN.done", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 16'd7, 8'd0, 1'b0);
    step();
    checkOutput("zeroN.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // hp=0 behaves as hp=1: back-to-back toggles
    applyStimulus(1'b1, 16'd0, 8'd2, 1'b0);
    step();
    checkOutput("zeroHp.start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    applyStimulus(1'b0, 16'd0, 8'd2, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      step();
      checkCountPhase("zeroHp", 1, 2, k);
    end
    step();
    checkOutput("zeroHp.done", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("zeroHp.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Abort with tog_q=1 after the 3rd toggle: hp=5, N=6
    applyStimulus(1'b1, 16'd5, 8'd6, 1'b0);
    step();
    applyStimulus(1'b0, 16'd5, 8'd6, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step();
      checkCountPhase("abort1", 5, 6, k);
    end
    applyStimulus(1'b0, 16'd5, 8'd6, 1'b1);
    step();
    checkOutput("abort1.restore", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 16'd5, 8'd6, 1'b0);
    step();
    checkOutput("abort1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("abort1.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Abort on the terminal tick: hp=2, N=2
    applyStimulus(1'b1, 16'd2, 8'd2, 1'b0);
    step();
    applyStimulus(1'b0, 16'd2, 8'd2, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      checkCountPhase("abortTerm", 2, 2, k);
    end
    applyStimulus(1'b0, 16'd2, 8'd2, 1'b1);
    step();
    checkOutput("abortTerm.restore", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 16'd2, 8'd2, 1'b0);
    step();
    checkOutput("abortTerm.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("abortTerm.noDone", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Abort with tog_q=0: straight to idle, no restore pulse
    applyStimulus(1'b1, 16'd1, 8'd3, 1'b0);
    step();
    applyStimulus(1'b0, 16'd1, 8'd3, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      step();
      checkCountPhase("abortEven", 1, 3, k);
    end
    applyStimulus(1'b0, 16'd1, 8'd3, 1'b1);
    step();
    checkOutput("abortEven.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // start and abort together in IDLE: start accepted
    applyStimulus(1'b1, 16'd1, 8'd1, 1'b1);
    step();
    checkOutput("startAbort.start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(1'b0, 16'd1, 8'd1, 1'b0);
    step();
    checkOutput("startAbort.tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
    step();
    checkOutput("startAbort.done", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    step();
    checkOutput("startAbort.idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    // abort in IDLE ignored: tog_q stays 1, no pulse
    applyStimulus(1'b0, 16'd0, 8'd0, 1'b1);
    step();
    checkOutput("idleAbort", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 16'd0, 8'd0, 1'b0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_burst_ctrl.md
Name: toggle_burst_ctrl

Overview:
Sequencer for the T flip-flop toggle datapath. On a start request it issues a programmed number of single-cycle toggle-enable pulses, spaced a programmed half-period apart, so a downstream T flip-flop produces a square-wave burst. It keeps a shadow of the flip-flop state and returns it to 0 on abort. It sits between the configuration/control logic and the T flip-flop bank, and reports busy/done to the requester.

Parameters:
CNT_W, 16, width of half-period counter and of half_period input
N_W, 8, width of toggle count, num_toggles input and toggles_left output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
start  input  1  request a burst; accepted only while busy=0
half_period  input  CNT_W  cycles between toggles; sampled at start acceptance
num_toggles  input  N_W  number of toggles in burst; sampled at start acceptance
abort  input  1  terminate an active burst
busy  output  1  burst in progress (states COUNT, RESTORE, DONE)
done  output  1  one-cycle pulse on normal burst completion
tog_en  output  1  one-cycle toggle-enable pulse to the T flip-flop
tog_q  output  1  shadow of the T flip-flop state (flips on every tog_en)
toggles_left  output  N_W  toggles remaining in the current burst

Behaviour:
- All outputs are registered. While rst=0: state IDLE, busy=0, done=0, tog_en=0, tog_q=0, toggles_left=0, counter=0. Assertion takes effect immediately, mid-burst included; no restore pulse.
- States: IDLE, COUNT, RESTORE, DONE.
- IDLE: start=1 at edge E0 latches the inputs. half_period=0 is treated as 1.
  - If num_toggles=0: go to DONE (done high in the cycle after E0).
  - Otherwise: go to COUNT with counter=hp-1 and toggles_left=num_toggles.
  - start and abort both high in IDLE: start is accepted and abort is ignored.
- COUNT, no abort:
  - counter>0: decrement.
  - counter=0: tog_en=1 for one cycle, tog_q flips, toggles_left decrements, counter reloads hp-1.
  - When toggles_left reaches 0, go to DONE.
- Toggle timing: toggle k (1..N) is high in the cycle following edge E0+k·hp. done is high in the cycle following edge E0+N·hp+1.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. busy drops in the cycle after done.
- abort=1 sampled in COUNT:
  - The normal tick of that cycle is suppressed, including a terminal tick.
  - tog_q=1: go to RESTORE. tog_en=1 for one cycle, tog_q returns to 0, then IDLE.
  - tog_q=0: go directly to IDLE.
  - No done pulse in either case. toggles_left is cleared to 0 on abort.
- abort in IDLE, RESTORE or DONE is ignored. start while busy=1 is ignored and not queued.
- tog_q always equals the parity of tog_en pulses issued since reset.
- Counter and toggle count wrap nowhere: hp max = 2^CNT_W-1, N max = 2^N_W-1.

Optional Feature:
Macro TOGGLE_BURST_AUTO_RELOAD_EN.
- Defined: on completion, DONE pulses done for one cycle and then reloads the latched hp and num_toggles and re-enters COUNT (busy stays 1). The burst repeats until abort. num_toggles=0 pulses done once and returns to IDLE.
- Undefined: one-shot behaviour as above.

Test Plan:
- Reset: rst=0 mid-burst (toggles_left=2) -> next sample shows all outputs 0, state IDLE; after release, start is accepted normally.
- Basic burst: hp=3, N=4, start at E0 -> tog_en pulses at E0+3, +6, +9, +12 (4 pulses); tog_q ends 0; done one cycle after E0+13; busy high for 14 cycles.
- Zero and minimum: N=0 -> done one cycle after E0, no tog_en. hp=0, N=2 -> tog_en on two consecutive cycles, tog_q ends 0.
- Abort with tog_q=1: hp=5, N=6, abort after the 3rd toggle -> exactly one RESTORE tog_en, tog_q=0, no done, busy=0 two cycles after abort.
- Abort colliding with terminal tick: hp=2, N=2, abort on the cycle of the 2nd tick -> 2nd toggle suppressed; RESTORE tog_en brings tog_q to 0; no done.
- Busy protection and auto-reload: start pulsed during a burst -> ignored. With TOGGLE_BURST_AUTO_RELOAD_EN, hp=1, N=2 -> done every 3 cycles and busy never drops until abort.
